ddpuf_meas_ctrl: RTL and testbench
==================================

DDPUF_MEAS_CTRL -- requirements
Module: ddpuf_meas_ctrl

Interface
REQ-001 The block SHALL have parameter N_BITS, default 128, meaning the number of response bits per run (one round per bit).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 4, meaning the cycles oscillators run before counting starts.
REQ-003 The block SHALL have the following ports:
- CLK  input  1  single system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- FSM_Start  input  1  run request, sampled only in IDLE.
- Duration  input  16  measurement window per round, in CLK cycles.
- RO_A_TICK  input  1  one-cycle strobe per edge of oscillator A, already synchronized to CLK.
- RO_B_TICK  input  1  one-cycle strobe per edge of oscillator B, already synchronized to CLK.
- RO_EN  output  1  oscillator enable.
- RO_SEL  output  7  challenge/pair index, equal to the current round number.
- FSM_Complete  output  1  run finished; level signal.
- PUF_Val  output  128  response from the last completed run.

Function
REQ-004 States SHALL be IDLE, SETTLE, MEASURE, COMPARE and DONE, held in one registered state variable.
REQ-005 IDLE SHALL move to SETTLE on the edge where FSM_Start=1, and SHALL make the following updates on that edge:
- Duration latched into dur_q; a value of 0 is latched as 1.
- Round counter cleared to 0.
- FSM_Complete cleared to 0.
REQ-006 Duration changes after the latch SHALL have no effect until the next run.
REQ-007 SETTLE SHALL last exactly SETTLE_CYC cycles, with RO_EN=1; count_a and count_b SHALL be held at 0 and ticks ignored.
REQ-008 MEASURE SHALL last exactly dur_q cycles, with RO_EN=1.
REQ-009 In each MEASURE cycle, count_a SHALL increment by 1 when RO_A_TICK=1 and count_b SHALL increment by 1 when RO_B_TICK=1; both may increment in the same cycle.
REQ-010 count_a and count_b SHALL be 16-bit and SHALL NOT wrap, since dur_q ≤ 65535.
REQ-011 COMPARE SHALL last one cycle with RO_EN=0.
REQ-012 In COMPARE, bit[round] of the internal result register SHALL be written as 1 when count_a > count_b, and as 0 otherwise (a tie gives 0).
REQ-013 Leaving COMPARE SHALL be decided by the round counter:
- If round < N_BITS-1: the round counter increments and the state returns to SETTLE.
- Otherwise: PUF_Val is loaded with the full result register and FSM_Complete is set to 1 on the same edge, and the state enters DONE.
REQ-014 PUF_Val SHALL change only at run completion or reset, never in partial form.
REQ-015 Latency: FSM_Complete SHALL rise exactly N_BITS*(SETTLE_CYC+dur_q+1) cycles after the edge that samples FSM_Start.
REQ-016 DONE SHALL keep FSM_Complete=1 and RO_EN=0 and SHALL return to IDLE on the next edge.
REQ-017 FSM_Complete SHALL stay high in IDLE until the next accepted FSM_Start.
REQ-018 FSM_Start SHALL be ignored in SETTLE, MEASURE, COMPARE and DONE; no restart and no queuing.
REQ-019 RO_SEL SHALL equal the round counter in every state and SHALL be 0 in IDLE.
REQ-020 RO_A_TICK and RO_B_TICK SHALL be ignored outside MEASURE.

Reset
REQ-021 When RST=1 at a rising edge, the block SHALL enter IDLE with all of the following cleared: RO_EN=0, RO_SEL=0, FSM_Complete=0, PUF_Val=0, counters=0, result register=0, dur_q=0.
REQ-022 Reset SHALL take priority over all other inputs, including mid-run, where it SHALL abort the run with no PUF_Val update.
REQ-023 After RST deasserts, the block SHALL accept FSM_Start on the first following edge.

Verification
REQ-024 Duration=10, RO_A_TICK=1 every cycle, RO_B_TICK=0, one FSM_Start pulse -> RO_EN high in SETTLE/MEASURE; FSM_Complete rises exactly 128*15=1920 cycles after the start edge; PUF_Val=all ones.
REQ-025 Duration=8, A ticks every cycle when RO_SEL is even and B ticks every cycle when RO_SEL is odd -> PUF_Val=0x5555...5555 (bit0=1).
REQ-026 Duration=4, A and B tick every cycle (tie) -> PUF_Val=0.
REQ-026 (cont.) Duration=0 -> treated as 1; completion at 128*6=768 cycles.
REQ-027 Second FSM_Start pulse 50 cycles into a run, plus Duration changed mid-run -> single completion at the original latency; PUF_Val unchanged until then.
REQ-028 RST=1 for 1 cycle at round 40 of a run that follows a prior all-ones result -> next edge: IDLE, RO_EN=0, FSM_Complete=0, PUF_Val=0.
REQ-028 (cont.) A fresh run after that reset completes normally.

Source files
------------

// File: rtl/ddpuf_meas_ctrl.sv
// Measurement sequencer for a delay-difference PUF: per response bit it settles
// the selected oscillator pair, counts both tick streams, and records which is faster.
module ddpuf_meas_ctrl #(
  parameter int N_BITS     = 128,
  parameter int SETTLE_CYC = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FSM_Start,
  input  logic [15:0]  Duration,
  input  logic         RO_A_TICK,
  input  logic         RO_B_TICK,
  output logic         RO_EN,
  output logic [6:0]   RO_SEL,
  output logic         FSM_Complete,
  output logic [127:0] PUF_Val
);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  localparam logic [6:0]  LAST_ROUND  = 7'(N_BITS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t         state_q, state_d;
  logic [15:0]    dur_q, dur_d;
  logic [15:0]    cyc_q, cyc_d;
  logic [15:0]    count_a_q, count_a_d;
  logic [15:0]    count_b_q, count_b_d;
  logic [6:0]     round_q, round_d;
  logic [127:0]   result_q, result_d;
  logic [127:0]   puf_q, puf_d;
  logic           complete_q, complete_d;

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    cyc_d      = cyc_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    round_d    = round_q;
    result_d   = result_q;
    puf_d      = puf_q;
    complete_d = complete_q;

    unique case (state_q)
      IDLE: begin
        if (FSM_Start) begin
          state_d    = SETTLE;
          dur_d      = (Duration == '0) ? 16'd1 : Duration;
          round_d    = '0;
          complete_d = 1'b0;
          cyc_d      = '0;
          count_a_d  = '0;
          count_b_d  = '0;
        end
      end
      SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          state_d = MEASURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      MEASURE: begin
        count_a_d = count_a_q + 16'(RO_A_TICK);
        count_b_d = count_b_q + 16'(RO_B_TICK);
        if (cyc_q == dur_q - 16'd1) begin
          state_d = COMPARE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      COMPARE: begin
        result_d[round_q] = (count_a_q > count_b_q);
        count_a_d         = '0;
        count_b_d         = '0;
        if (round_q < LAST_ROUND) begin
          round_d = round_q + 7'd1;
          state_d = SETTLE;
        end else begin
          // Publish including the bit written on this same edge.
          puf_d      = result_d;
          complete_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        round_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      cyc_q      <= '0;
      count_a_q  <= '0;
      count_b_q  <= '0;
      round_q    <= '0;
      result_q   <= '0;
      puf_q      <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      cyc_q      <= cyc_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      round_q    <= round_d;
      result_q   <= result_d;
      puf_q      <= puf_d;
      complete_q <= complete_d;
    end
  end

  assign RO_EN        = (state_q == SETTLE) || (state_q == MEASURE);
  assign RO_SEL       = round_q;
  assign FSM_Complete = complete_q;
  assign PUF_Val      = puf_q;

endmodule

// File: tb/tb_ddpuf_meas_ctrl.sv
// Self-checking bench for ddpuf_meas_ctrl: timing and per-round tick windows are
// derived arithmetically from the run parameters, response bits from tick tallies.
module tb_ddpuf_meas_ctrl;

  localparam int unsigned N = 128;
  localparam int unsigned S = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         FSM_Start = 1'b0;
  logic [15:0]  Duration = '0;
  logic         RO_A_TICK = 1'b0;
  logic         RO_B_TICK = 1'b0;
  logic         RO_EN;
  logic [6:0]   RO_SEL;
  logic         FSM_Complete;
  logic [127:0] PUF_Val;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_puf = '0;

  ddpuf_meas_ctrl #(.N_BITS(N), .SETTLE_CYC(S)) dut (
    .CLK(CLK), .RST(RST), .FSM_Start(FSM_Start), .Duration(Duration),
    .RO_A_TICK(RO_A_TICK), .RO_B_TICK(RO_B_TICK), .RO_EN(RO_EN),
    .RO_SEL(RO_SEL), .FSM_Complete(FSM_Complete), .PUF_Val(PUF_Val)
  );

  always #5 CLK = ~CLK;

  // Runs one measurement starting from the current negedge. mode: 0 random ticks,
  // 1 A only, 2 A on even rounds / B on odd rounds, 3 both always.
  // disturb pulses Start and changes Duration mid-run; abort_k>0 resets after edge abort_k.
  task automatic do_run(input int unsigned dur, input int unsigned mode,
                        input bit disturb, input int unsigned abort_k, input string name);
    int unsigned d, p, l, r, e;
    int unsigned na[N];
    int unsigned nb[N];
    logic a, b;
    logic [127:0] old_puf, new_puf, want_puf;
    logic exp_en, exp_c;
    logic [6:0] exp_sel;
    d = (dur == 0) ? 1 : dur;
    p = S + d + 1;
    l = N * p;
    old_puf = exp_puf;
    for (int unsigned i = 0; i < N; i++) begin na[i] = 0; nb[i] = 0; end

    FSM_Start = 1'b1; Duration = 16'(dur); RO_A_TICK = 1'b0; RO_B_TICK = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    FSM_Start = 1'b0;

    new_puf = '0;
    for (int unsigned k = 0; k <= l; k++) begin
      if (k == l) begin
        for (int unsigned i = 0; i < N; i++) new_puf[i] = (na[i] > nb[i]);
      end
      exp_c   = (k >= l);
      exp_en  = (k < l) && ((k % p) < S + d);
      exp_sel = (k < l) ? 7'(k / p) : 7'(N - 1);
      want_puf = (k < l) ? old_puf : new_puf;
      checks += 4;
      if (FSM_Complete !== exp_c) begin
        failures++; $display("FAIL %s complete k=%0d got=%b exp=%b", name, k, FSM_Complete, exp_c);
      end
      if (RO_EN !== exp_en) begin
        failures++; $display("FAIL %s ro_en k=%0d got=%b exp=%b", name, k, RO_EN, exp_en);
      end
      if (RO_SEL !== exp_sel) begin
        failures++; $display("FAIL %s ro_sel k=%0d got=%0d exp=%0d", name, k, RO_SEL, exp_sel);
      end
      if (PUF_Val !== want_puf) begin
        failures++; $display("FAIL %s puf k=%0d got=%h exp=%h", name, k, PUF_Val, want_puf);
      end
      if (k == l) break;

      if (abort_k != 0 && k == abort_k) begin
        RST = 1'b1; FSM_Start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        checks += 4;
        if (RO_EN !== 1'b0) begin
          failures++; $display("FAIL %s abort_ro_en got=%b exp=0", name, RO_EN);
        end
        if (RO_SEL !== 7'd0) begin
          failures++; $display("FAIL %s abort_ro_sel got=%0d exp=0", name, RO_SEL);
        end
        if (FSM_Complete !== 1'b0) begin
          failures++; $display("FAIL %s abort_complete got=%b exp=0", name, FSM_Complete);
        end
        if (PUF_Val !== '0) begin
          failures++; $display("FAIL %s abort_puf got=%h exp=0", name, PUF_Val);
        end
        exp_puf = '0;
        return;
      end

      // Stimulus for edge k+1, which belongs to round r.
      r = k / p;
      e = k + 1 - r * p;
      case (mode)
        1: begin a = 1'b1; b = 1'b0; end
        2: begin a = (r % 2 == 0); b = (r % 2 == 1); end
        3: begin a = 1'b1; b = 1'b1; end
        default: begin a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); end
      endcase
      RO_A_TICK = a; RO_B_TICK = b;
      if (e >= S + 1 && e <= S + d) begin
        na[r] += (a ? 1 : 0);
        nb[r] += (b ? 1 : 0);
      end
      if (disturb) begin
        FSM_Start = (k == 50);
        if (k == 60) Duration = 16'($urandom_range(1, 65535));
      end
      @(posedge CLK);
      @(negedge CLK);
    end

    exp_puf = new_puf;
    FSM_Start = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      RO_A_TICK = 1'($urandom_range(0, 1)); RO_B_TICK = 1'($urandom_range(0, 1));
      @(posedge CLK);
      @(negedge CLK);
      checks += 4;
      if (FSM_Complete !== 1'b1) begin
        failures++; $display("FAIL %s idle_complete j=%0d got=%b exp=1", name, j, FSM_Complete);
      end
      if (RO_EN !== 1'b0) begin
        failures++; $display("FAIL %s idle_ro_en j=%0d got=%b exp=0", name, j, RO_EN);
      end
      if (RO_SEL !== 7'd0) begin
        failures++; $display("FAIL %s idle_ro_sel j=%0d got=%0d exp=0", name, j, RO_SEL);
      end
      if (PUF_Val !== exp_puf) begin
        failures++; $display("FAIL %s idle_puf j=%0d got=%h exp=%h", name, j, PUF_Val, exp_puf);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; FSM_Start = 1'b1; Duration = 16'd5;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    checks += 4;
    if (RO_EN !== 1'b0) begin failures++; $display("FAIL reset ro_en got=%b exp=0", RO_EN); end
    if (RO_SEL !== 7'd0) begin failures++; $display("FAIL reset ro_sel got=%0d exp=0", RO_SEL); end
    if (FSM_Complete !== 1'b0) begin
      failures++; $display("FAIL reset complete got=%b exp=0", FSM_Complete);
    end
    if (PUF_Val !== '0) begin failures++; $display("FAIL reset puf got=%h exp=0", PUF_Val); end
    RST = 1'b0; FSM_Start = 1'b0;
    exp_puf = '0;
  endtask

  task automatic test_all_ones();       do_run(10, 1, 1'b0, 0, "all_ones");    endtask
  task automatic test_alternating();    do_run(8, 2, 1'b0, 0, "alternating");  endtask
  task automatic test_tie();            do_run(4, 3, 1'b0, 0, "tie");          endtask
  task automatic test_zero_duration();  do_run(0, 0, 1'b0, 0, "zero_dur");     endtask
  task automatic test_ignore_start();   do_run(10, 0, 1'b1, 0, "ignore_start"); endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 3; i++) do_run($urandom_range(1, 12), 0, 1'b0, 0, "random");
  endtask

  task automatic test_abort();
    do_run(10, 1, 1'b0, 0, "pre_abort");
    do_run(10, 1, 1'b0, 40 * (S + 10 + 1) + 5, "abort");
    do_run(6, 0, 1'b0, 0, "post_abort");
  endtask

  task automatic test_back_to_back();
    do_run(2, 0, 1'b0, 0, "b2b_first");
    do_run(3, 0, 1'b0, 0, "b2b_second");
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_all_ones();
    test_alternating();
    test_tie();
    test_zero_duration();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
